// File: rtl/psg_ctrl.sv
// psg_ctrl: TurboSound-style bus controller for up to four AY/YM PSGs.
// Decodes Z80 I/O cycles on FFFD/BFFD, keeps the chip-select register,
// sequences per-chip BDIR/BC1 strobes with a recovery gap, generates the
// shared PSG clock and requests CPU wait states.
module psg_ctrl #(
    parameter int CHIPS           = 2,
    parameter int WAIT_CYCLES     = 2,
    parameter int RECOVERY_CYCLES = 3
) (
    input  logic             rst_n,
    input  logic             clk28,
    input  logic             en,
    input  logic             psg_fast,
    input  logic [15:0]      a,
    input  logic [7:0]       d,
    input  logic             iorq,
    input  logic             m1,
    input  logic             wr,
    input  logic             rd,
    output logic             ay_clk,
    output logic [CHIPS-1:0] ay_bc1,
    output logic [CHIPS-1:0] ay_bdir,
    output logic [1:0]       chip_sel,
    output logic             d_out_active,
    output logic             ext_wait
);

    localparam logic [2:0] WAIT_C   = 3'(WAIT_CYCLES);
    localparam logic [2:0] REC_LAST = 3'(RECOVERY_CYCLES - 1);
    localparam logic [2:0] CHIPS_C  = 3'(CHIPS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_RECOVER
    } state_t;

    typedef enum logic [1:0] {
        K_LATCH,
        K_WRITE,
        K_READ
    } kind_t;

    // Registered copy of the bus (only the address bits the decoder needs).
    logic       a15_reg;
    logic       a14_reg;
    logic       a1_reg;
    logic [7:0] d_reg;
    logic       iorq_reg;
    logic       m1_reg;
    logic       wr_reg;
    logic       rd_reg;

    // Address bits that play no part in the partial decode.
    logic unused_addr;
    assign unused_addr = ^{a[13:2], a[0]};

    state_t     state_reg;
    logic [2:0] rec_cnt_reg;
    logic [2:0] wait_cnt_reg;
    logic       wait_reg;
    // Set once the current I/O cycle has been acted on; cleared when iorq
    // drops, so a long (wait-stretched) cycle is only serviced once.
    logic       consumed_reg;

    logic [2:0] div_cnt_reg;
    logic       fast_reg;

    // Sample the CPU bus once per clk28 before decoding.
    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            a15_reg  <= 1'b0;
            a14_reg  <= 1'b0;
            a1_reg   <= 1'b0;
            d_reg    <= 8'h00;
            iorq_reg <= 1'b0;
            m1_reg   <= 1'b0;
            wr_reg   <= 1'b0;
            rd_reg   <= 1'b0;
        end else begin
            a15_reg  <= a[15];
            a14_reg  <= a[14];
            a1_reg   <= a[1];
            d_reg    <= d;
            iorq_reg <= iorq;
            m1_reg   <= m1;
            wr_reg   <= wr;
            rd_reg   <= rd;
        end
    end

    logic       base_dec;
    logic       latch_dec;
    logic       read_dec;
    logic       write_dec;
    logic       sel_cmd;
    logic       pending;
    logic       accept;
    logic       sel_accept;
    logic       leave;
    logic [1:0] sel_idx;
    kind_t      dec_kind;

    assign base_dec   = en && iorq_reg && !m1_reg && a15_reg && !a1_reg;
    assign latch_dec  = base_dec && a14_reg && wr_reg;
    assign read_dec   = base_dec && a14_reg && rd_reg && !wr_reg;
    assign write_dec  = base_dec && !a14_reg && wr_reg;
    assign sel_cmd    = latch_dec && (d_reg[7:2] == 6'b111111);
    assign pending    = (latch_dec || read_dec || write_dec) && !consumed_reg;
    assign accept     = (state_reg == ST_IDLE) && pending && !sel_cmd;
    assign sel_accept = (state_reg == ST_IDLE) && pending && sel_cmd;
    assign leave      = (state_reg == ST_ACTIVE) && (!iorq_reg || !en);
    assign sel_idx    = ~d_reg[1:0];

    // Classify the decoded access into the strobe pattern it needs.
    always_comb begin
        dec_kind = K_READ;
        if (write_dec) begin
            dec_kind = K_WRITE;
        end else if (latch_dec) begin
            dec_kind = K_LATCH;
        end
    end

    // Access sequencer: IDLE -> ACTIVE (strobes) -> RECOVER (gap) -> IDLE.
    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            rec_cnt_reg  <= 3'd0;
            wait_cnt_reg <= 3'd0;
            wait_reg     <= 1'b0;
            consumed_reg <= 1'b0;
            chip_sel     <= 2'd0;
            d_out_active <= 1'b0;
        end else begin
            consumed_reg <= iorq_reg && (consumed_reg || accept || sel_accept);
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        state_reg    <= ST_ACTIVE;
                        wait_reg     <= (WAIT_C != 3'd0);
                        wait_cnt_reg <= 3'd1;
                        d_out_active <= (dec_kind == K_READ);
                    end else if (sel_accept) begin
                        state_reg   <= ST_RECOVER;
                        rec_cnt_reg <= 3'd0;
                        if ({1'b0, sel_idx} < CHIPS_C) begin
                            chip_sel <= sel_idx;
                        end
                    end
                end
                ST_ACTIVE: begin
                    if (leave) begin
                        state_reg    <= ST_RECOVER;
                        rec_cnt_reg  <= 3'd0;
                        wait_reg     <= 1'b0;
                        d_out_active <= 1'b0;
                    end else begin
                        wait_reg <= (wait_cnt_reg < WAIT_C);
                        if (wait_cnt_reg != 3'd7) begin
                            wait_cnt_reg <= wait_cnt_reg + 3'd1;
                        end
                    end
                end
                ST_RECOVER: begin
                    if (rec_cnt_reg >= REC_LAST) begin
                        state_reg <= ST_IDLE;
                    end else begin
                        rec_cnt_reg <= rec_cnt_reg + 3'd1;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // A new cycle that arrives during the gap must stall the CPU until
    // the sequencer can take it, in addition to the fixed ACTIVE wait.
    assign ext_wait = wait_reg || ((state_reg == ST_RECOVER) && pending);

    genvar gi;
    generate
        for (gi = 0; gi < CHIPS; gi++) begin : g_chip
            localparam logic [1:0] IDX = 2'(gi);
            logic bdir_reg;
            logic bc1_reg;

            // Per-chip strobes: loaded on entry to ACTIVE, cleared on exit.
            always_ff @(posedge clk28 or negedge rst_n) begin
                if (!rst_n) begin
                    bdir_reg <= 1'b0;
                    bc1_reg  <= 1'b0;
                end else if (accept) begin
                    bdir_reg <= (chip_sel == IDX) && (dec_kind != K_READ);
                    bc1_reg  <= (chip_sel == IDX) && (dec_kind != K_WRITE);
                end else if (leave) begin
                    bdir_reg <= 1'b0;
                    bc1_reg  <= 1'b0;
                end
            end

            assign ay_bdir[gi] = bdir_reg;
            assign ay_bc1[gi]  = bc1_reg;
        end
    endgenerate

    logic [2:0] div_term;
    assign div_term = fast_reg ? 3'd3 : 3'd7;

    // PSG clock divider; the speed is re-sampled only when ay_clk toggles,
    // so every half-period is a whole 4 or 8 clk28 cycles.
    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_reg <= 3'd0;
            ay_clk      <= 1'b0;
            fast_reg    <= 1'b0;
        end else if (div_cnt_reg == div_term) begin
            div_cnt_reg <= 3'd0;
            ay_clk      <= ~ay_clk;
            fast_reg    <= psg_fast;
        end else begin
            div_cnt_reg <= div_cnt_reg + 3'd1;
        end
    end

endmodule

// File: tb/tb_psg_ctrl.sv
// Testbench for psg_ctrl: directed scenarios plus randomized I/O cycles,
// checked against a transaction-level model of the decoder and sequencer.
module tb_psg_ctrl;

    localparam int CHIPS = 2;
    localparam int WAITC = 2;
    localparam int RECC  = 3;
    localparam int GAP   = 10;

    logic             clk28 = 1'b0;
    logic             rst_n;
    logic             en;
    logic             psg_fast;
    logic [15:0]      a;
    logic [7:0]       d;
    logic             iorq;
    logic             m1;
    logic             wr;
    logic             rd;
    logic             ay_clk;
    logic [CHIPS-1:0] ay_bc1;
    logic [CHIPS-1:0] ay_bdir;
    logic [1:0]       chip_sel;
    logic             d_out_active;
    logic             ext_wait;

    always #5 clk28 = ~clk28;

    psg_ctrl #(
        .CHIPS(CHIPS),
        .WAIT_CYCLES(WAITC),
        .RECOVERY_CYCLES(RECC)
    ) dut (
        .rst_n(rst_n),
        .clk28(clk28),
        .en(en),
        .psg_fast(psg_fast),
        .a(a),
        .d(d),
        .iorq(iorq),
        .m1(m1),
        .wr(wr),
        .rd(rd),
        .ay_clk(ay_clk),
        .ay_bc1(ay_bc1),
        .ay_bdir(ay_bdir),
        .chip_sel(chip_sel),
        .d_out_active(d_out_active),
        .ext_wait(ext_wait)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int m_sel  = 0;

    // Cumulative activity counters, sampled on the falling edge.
    int       pat_cnt [4][4];
    int       rise_cnt [4];
    int       last_rise [4];
    logic [1:0] prev_pat [4];
    int       d_cnt = 0;
    int       w_cnt = 0;

    always @(posedge clk28) cyc <= cyc + 1;

    initial begin
        for (int c = 0; c < 4; c++) begin
            for (int p = 0; p < 4; p++) pat_cnt[c][p] = 0;
            rise_cnt[c]  = 0;
            last_rise[c] = 0;
            prev_pat[c]  = 2'b00;
        end
    end

    always @(negedge clk28) begin
        for (int c = 0; c < CHIPS; c++) begin
            logic [1:0] p;
            p = {ay_bdir[c], ay_bc1[c]};
            pat_cnt[c][p] = pat_cnt[c][p] + 1;
            if (p != 2'b00 && prev_pat[c] == 2'b00) begin
                rise_cnt[c]  = rise_cnt[c] + 1;
                last_rise[c] = cyc;
            end
            prev_pat[c] = p;
        end
        if (d_out_active) d_cnt = d_cnt + 1;
        if (ext_wait) w_cnt = w_cnt + 1;
    end

    task automatic tick();
        @(posedge clk28);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // One complete I/O cycle of len clk28 with iorq high, then idle time.
    task automatic run_io(input logic [15:0] addr, input logic [7:0] data,
                          input logic w, input logic r, input logic m1v,
                          input int len, input string tag);
        logic base, is_latch, is_read, is_write, is_sel, is_acc;
        int   exp_pat, old_sel, new_sel, idx, rs, c1, c2;
        int   p0 [4][4];
        int   r0 [4];
        int   d0, w0, hi, ew;

        base     = en && !m1v && addr[15] && !addr[1];
        is_latch = base && addr[14] && w;
        is_read  = base && addr[14] && r && !w;
        is_write = base && !addr[14] && w;
        is_sel   = is_latch && (data[7:2] == 6'b111111);
        is_acc   = (is_latch && !is_sel) || is_read || is_write;
        exp_pat  = is_read ? 1 : (is_write ? 2 : 3);
        old_sel  = m_sel;
        new_sel  = m_sel;
        idx      = 3 - int'(data[1:0]);
        if (is_sel && idx < CHIPS) new_sel = idx;

        for (int c = 0; c < 4; c++) begin
            for (int p = 0; p < 4; p++) p0[c][p] = pat_cnt[c][p];
            r0[c] = rise_cnt[c];
        end
        d0 = d_cnt;
        w0 = w_cnt;
        c1 = 0;
        c2 = 0;

        a = addr; d = data; wr = w; rd = r; m1 = m1v; iorq = 1'b1;
        rs = cyc;
        for (int k = 1; k <= len + GAP; k++) begin
            tick();
            if (k == len) begin
                iorq = 1'b0; wr = 1'b0; rd = 1'b0; m1 = 1'b0;
            end
            if (k == 1) c1 = int'(chip_sel);
            if (k == 2) c2 = int'(chip_sel);
        end

        for (int c = 0; c < CHIPS; c++) begin
            hi = (pat_cnt[c][1] - p0[c][1]) + (pat_cnt[c][2] - p0[c][2]) + (pat_cnt[c][3] - p0[c][3]);
            check($sformatf("%s_hi%0d", tag, c), hi, (is_acc && c == old_sel) ? len : 0);
        end
        if (is_acc) begin
            check($sformatf("%s_pat", tag), pat_cnt[old_sel][exp_pat] - p0[old_sel][exp_pat], len);
            check($sformatf("%s_rises", tag), rise_cnt[old_sel] - r0[old_sel], 1);
            check($sformatf("%s_start", tag), last_rise[old_sel], rs + 2);
        end
        ew = is_acc ? ((len < WAITC) ? len : WAITC) : 0;
        check($sformatf("%s_dout", tag), d_cnt - d0, is_read ? len : 0);
        check($sformatf("%s_wait", tag), w_cnt - w0, ew);
        check($sformatf("%s_sel1", tag), c1, old_sel);
        check($sformatf("%s_sel2", tag), c2, new_sel);
        check($sformatf("%s_self", tag), chip_sel, new_sel);
        m_sel = new_sel;
        $display("io %s a=%h d=%h wr=%0b rd=%0b m1=%0b en=%0b len=%0d -> chip_sel=%0d", tag, addr, data, w, r, m1v, en, len, chip_sel);
    endtask

    task automatic wait_toggle(output int n);
        logic prev;
        prev = ay_clk;
        n = 0;
        do begin
            tick();
            n++;
        end while (ay_clk == prev && n < 40);
    endtask

    initial begin
        logic bd [24];
        logic ewh [24];
        int   i1, f, i2, h, nb;
        logic found;
        logic [15:0] ra;
        logic [7:0]  rdat;
        logic        rw;

        rst_n = 1'b0; en = 1'b1; psg_fast = 1'b0;
        a = 16'h0000; d = 8'h00; iorq = 1'b0; m1 = 1'b0; wr = 1'b0; rd = 1'b0;
        tick();
        tick();
        check("rst_ay_clk", ay_clk, 0);
        check("rst_bc1", ay_bc1, 0);
        check("rst_bdir", ay_bdir, 0);
        check("rst_chip_sel", chip_sel, 0);
        check("rst_dout", d_out_active, 0);
        check("rst_wait", ext_wait, 0);
        rst_n = 1'b1;
        repeat (4) tick();

        // Address latch then data write to chip 0.
        run_io(16'hFFFD, 8'h07, 1'b1, 1'b0, 1'b0, 3, "latch07");
        run_io(16'hBFFD, 8'h3F, 1'b1, 1'b0, 1'b0, 3, "write3F");

        // Select chip 1, latch on it, then an out-of-range select.
        run_io(16'hFFFD, 8'hFE, 1'b1, 1'b0, 1'b0, 3, "selFE");
        run_io(16'hFFFD, 8'h0E, 1'b1, 1'b0, 1'b0, 3, "latch0E");
        run_io(16'hFFFD, 8'hFC, 1'b1, 1'b0, 1'b0, 3, "selFC");

        // Register read from chip 1.
        run_io(16'hFFFD, 8'h00, 1'b0, 1'b1, 1'b0, 4, "read");

        // Back-to-back OUTs to BFFD with a single-cycle iorq gap.
        a = 16'hBFFD; d = 8'h12;
        for (int t = 0; t < 24; t++) begin
            iorq = (t < 3) || (t >= 4 && t < 12);
            wr   = iorq;
            tick();
            bd[t]  = ay_bdir[1];
            ewh[t] = ext_wait;
        end
        iorq = 1'b0; wr = 1'b0;
        repeat (GAP) tick();
        found = 1'b0; i1 = 0; f = 0; i2 = 0;
        for (int t = 0; t < 24; t++) if (!found && bd[t]) begin i1 = t; found = 1'b1; end
        if (found) begin
            found = 1'b0;
            for (int t = i1; t < 24; t++) if (!found && !bd[t]) begin f = t; found = 1'b1; end
        end
        if (found) begin
            found = 1'b0;
            for (int t = f; t < 20; t++) if (!found && bd[t]) begin i2 = t; found = 1'b1; end
        end
        check("b2b_found", found, 1);
        if (found && f + 3 < 24 && i2 + 2 < 24) begin
            check("b2b_first_start", i1, 1);
            check("b2b_first_len", f - i1, 3);
            check("b2b_gap", i2 - f, RECC + 1);
            check("b2b_wait_rec0", ewh[f], 1);
            check("b2b_wait_rec1", ewh[f+1], 1);
            check("b2b_wait_rec2", ewh[f+2], 1);
            check("b2b_wait_idle", ewh[f+3], 0);
            check("b2b_wait_act0", ewh[i2], 1);
            check("b2b_wait_act1", ewh[i2+1], 1);
            check("b2b_wait_act2", ewh[i2+2], 0);
        end
        $display("b2b first=%0d end=%0d second=%0d", i1, f, i2);

        // Divider speed change in the middle of a half-period.
        wait_toggle(nb);
        repeat (3) tick();
        psg_fast = 1'b1;
        wait_toggle(nb);
        check("div_slow_half", 3 + nb, 8);
        wait_toggle(h);
        check("div_fast_half1", h, 4);
        wait_toggle(h);
        check("div_fast_half2", h, 4);
        tick();
        psg_fast = 1'b0;
        wait_toggle(nb);
        check("div_fast_last", 1 + nb, 4);
        wait_toggle(h);
        check("div_slow_again", h, 8);
        $display("divider halves checked, psg_fast=%0b", psg_fast);

        // Asynchronous reset in the middle of an ACTIVE write on chip 1.
        a = 16'hBFFD; d = 8'hA5; wr = 1'b1; iorq = 1'b1;
        repeat (3) tick();
        check("arst_pre_bdir", ay_bdir, 2'b10);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_bdir", ay_bdir, 0);
        check("arst_bc1", ay_bc1, 0);
        check("arst_chip_sel", chip_sel, 0);
        check("arst_wait", ext_wait, 0);
        tick();
        iorq = 1'b0; wr = 1'b0;
        tick();
        rst_n = 1'b1;
        m_sel = 0;
        repeat (6) tick();
        $display("async reset during write checked");

        // en dropped during an ACTIVE latch on chip 0.
        a = 16'hFFFD; d = 8'h07; wr = 1'b1; iorq = 1'b1;
        repeat (3) tick();
        check("abort_pre_bdir", ay_bdir, 2'b01);
        check("abort_pre_bc1", ay_bc1, 2'b01);
        en = 1'b0;
        tick();
        check("abort_bdir", ay_bdir, 0);
        check("abort_bc1", ay_bc1, 0);
        repeat (2) tick();
        check("abort_hold", {ay_bdir, ay_bc1}, 0);
        iorq = 1'b0; wr = 1'b0;
        repeat (2) tick();
        en = 1'b1;
        repeat (6) tick();
        $display("en abort checked");
        run_io(16'hBFFD, 8'h55, 1'b1, 1'b0, 1'b0, 2, "post_abort");

        // Randomized I/O cycles against the transaction model.
        for (int n = 0; n < 40; n++) begin
            ra = 16'($urandom);
            case ($urandom_range(0, 3))
                0: begin ra[15] = 1'b1; ra[14] = 1'b1; ra[1] = 1'b0; end
                1: begin ra[15] = 1'b1; ra[14] = 1'b0; ra[1] = 1'b0; end
                2: begin ra[15] = 1'b1; ra[1] = 1'b1; end
                default: ra[15] = 1'b0;
            endcase
            if ($urandom_range(0, 3) == 0) ra = ($urandom_range(0, 1) == 1) ? 16'hFFFD : 16'hBFFD;
            rdat = 8'($urandom);
            if ($urandom_range(0, 1) == 1) rdat[7:2] = 6'b111111;
            rw = ($urandom_range(0, 1) == 1);
            en = ($urandom_range(0, 7) != 0);
            run_io(ra, rdat, rw, !rw, ($urandom_range(0, 7) == 0),
                   int'($urandom_range(1, 5)), $sformatf("rnd%0d", n));
            en = 1'b1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/psg_ctrl.md
# psg_ctrl

Parametrised AY/YM sound-chip bus controller for up to four PSGs (TurboSound-style). It decodes Z80 I/O cycles on ports FFFD/BFFD, keeps a chip-select register, and drives per-chip BDIR/BC1 strobes through a sequenced access FSM with enforced recovery time. It generates the shared PSG clock with a glitch-free selectable divider, and it requests CPU wait states. It sits between the CPU bus and the PSG pins, replacing the single-chip strobe decoder.

## Interface
- CHIPS, 2, number of PSGs driven (1..4)
- WAIT_CYCLES, 2, clk28 cycles ext_wait is held from start of ACTIVE (1..7)
- RECOVERY_CYCLES, 3, minimum strobe-off clk28 cycles after an access (1..7)
- rst_n  input  1  asynchronous active-low reset
- clk28  input  1  28 MHz system clock
- en  input  1  block enable; 0 masks all decode
- psg_fast  input  1  0: PSG clock 1.75 MHz (÷16); 1: 3.5 MHz (÷8)
- bus  cpu_bus  —  CPU bus; uses a[15:0], d[7:0], iorq, m1, wr, rd
- ay_clk  output  1  PSG clock
- ay_bc1  output  CHIPS  per-chip BC1
- ay_bdir  output  CHIPS  per-chip BDIR
- chip_sel  output  2  currently selected chip index
- d_out_active  output  1  PSG read data drives CPU bus
- ext_wait  output  1  wait request to CPU

## Operation
- Decode uses bus inputs registered once in clk28, which gives one clock of latency.
- The base condition is en && iorq && !m1 && a[15] && !a[1]. Each port is that condition plus:
  - FFFD write (a[14]=1, wr): LATCH.
  - FFFD read (a[14]=1, rd): READ.
  - BFFD write (a[14]=0, wr): WRITE.
  - BFFD read: ignored.
- Chip select:
  - A LATCH with d[7:2]=6'b111111 is a select command, not an address latch.
  - Index = ~d[1:0]: FF→0, FE→1, FD→2, FC→3.
  - chip_sel updates only if index < CHIPS; otherwise it is unchanged.
  - No strobes are issued for a select command.
- FSM states IDLE, ACTIVE, RECOVER:
  - IDLE→ACTIVE on a decoded LATCH/WRITE/READ (not a select command). The kind and target chip (chip_sel) are captured at entry.
  - IDLE→RECOVER on a select command, with no strobes.
  - ACTIVE: only the captured chip's strobes are driven. LATCH: bdir=1, bc1=1. WRITE: bdir=1, bc1=0. READ: bdir=0, bc1=1. All other chips stay 0.
  - ACTIVE→RECOVER when the registered iorq is 0, or when en is 0 (abort).
  - RECOVER: all strobes 0, counting RECOVERY_CYCLES. Then →IDLE.
  - A decode arriving during RECOVER is accepted at the first IDLE cycle if still present, and it is held off by ext_wait.
- d_out_active = 1 only in ACTIVE with kind READ.
- ext_wait:
  - Asserted for the first WAIT_CYCLES cycles of ACTIVE.
  - Also asserted whenever a decode is pending while the FSM is in RECOVER.
- Clock divider:
  - A 3-bit counter toggles ay_clk on terminal count: 7 for ÷16, 3 for ÷8.
  - psg_fast is sampled only at a toggle, so there are no runt pulses.
  - A mode change takes effect on the next half-period.

## Timing
- Reset values: ay_clk=0, ay_bc1=0, ay_bdir=0, chip_sel=0, d_out_active=0, ext_wait=0, FSM=IDLE, divider=0.
- Strobes assert 2 clk28 edges after iorq rises: one edge for the input register, one for the FSM.
- Strobes deassert 2 edges after iorq falls. The next strobe assertion is at least RECOVERY_CYCLES+1 edges later.
- The select command takes effect on chip_sel 2 edges after iorq rises. An access decoded after it completes uses the new value.
- A select and a LATCH can never overlap, because they are one I/O cycle each.
- Reset mid-access forces all outputs to reset values immediately (asynchronous).
- With CHIPS=1, select commands never change chip_sel.

## Test plan
- Write FFFD d=07 then BFFD d=3F, CHIPS=2, after reset:
  - chip 0 sees bdir=1/bc1=1, then bdir=1/bc1=0.
  - ay_bdir[1] and ay_bc1[1] stay 0.
  - RECOVER lasts 3 cycles between the two accesses.
- Write FFFD d=FE, then write FFFD d=0E:
  - chip_sel=1 with no strobes for the first write.
  - ay_bdir[1]=ay_bc1[1]=1 for the second; chip 0 stays idle.
  - Then write FFFD d=FC with CHIPS=2: chip_sel stays 1.
- Read FFFD with chip_sel=1:
  - ay_bc1[1]=1, bdir=0.
  - d_out_active=1 for the ACTIVE duration; ext_wait high for the first 2 cycles.
- Back-to-back OUT to BFFD with iorq gap of 1 clk28:
  - ext_wait asserts during RECOVER.
  - The second strobe begins exactly 4 edges after the first strobe's end.
- psg_fast toggled 0→1 mid half-period:
  - Current half-period stays 8 clk28.
  - Following half-periods are 4 clk28.
  - No ay_clk pulse shorter than 4 cycles.
- rst_n low during ACTIVE WRITE, and separately en=0 during ACTIVE:
  - With rst_n low, all strobes are 0 and chip_sel=0 immediately.
  - With en=0, strobes drop on the next edge and the FSM enters RECOVER.
